// File: rtl/spi_ram_target.sv
// SPI Mode-0 RAM target (READ 0x03 / WRITE 0x02, 1-byte address, auto-increment) with a backdoor port.
// Optional RDSR (0x05) status command is enabled by defining SPI_RAM_TARGET_RDSR_EN.
module spi_ram_target #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic              bd_we,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata,
  output logic              busy
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          is_wr_q, is_wr_d;
  logic          pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          cs_prev_q, cs_prev_d;
  logic          sck_prev_q;
  logic [7:0]    bd_rdata_q;
  logic [7:0]    mem_q [MEM_BYTES];

  // Synchronizers are deliberately not reset so the true pin level is known
  // as soon as reset is released.
  logic cs_meta_q, cs_sync_q, sck_meta_q, sck_sync_q, mosi_meta_q, mosi_sync_q;

  always_ff @(posedge clk) begin
    cs_meta_q   <= cs_n;
    cs_sync_q   <= cs_meta_q;
    sck_meta_q  <= sck;
    sck_sync_q  <= sck_meta_q;
    mosi_meta_q <= mosi;
    mosi_sync_q <= mosi_meta_q;
  end

`ifdef SPI_RAM_TARGET_RDSR_EN
  logic [7:0] status_q, status_d;
  logic       rdsr_q, rdsr_d;
  logic       wr_done_q, wr_done_d;
`endif

  logic          sck_rise, sck_fall, cs_fall, byte_done, spi_we;
  logic [7:0]    rx_byte;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] bd_idx;

  assign sck_rise  = sck_sync_q & ~sck_prev_q;
  assign sck_fall  = ~sck_sync_q & sck_prev_q;
  // cs_prev_q resets low, so a frame already in progress at reset release
  // is not mistaken for a new cs_n fall.
  assign cs_fall   = cs_prev_q & ~cs_sync_q;
  assign rx_byte   = {rx_q[6:0], mosi_sync_q};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign addr_inc  = addr_q + AW'(1);
  assign bd_idx    = bd_addr[AW-1:0];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    pend_d    = pend_q;
    busy_d    = ~cs_sync_q;
    cs_prev_d = cs_sync_q;
    spi_we    = 1'b0;
`ifdef SPI_RAM_TARGET_RDSR_EN
    status_d  = status_q;
    rdsr_d    = rdsr_q;
    wr_done_d = wr_done_q;
`endif
    if (state_q != IDLE && cs_sync_q) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
`ifdef SPI_RAM_TARGET_RDSR_EN
      if (state_q != CMD)
        status_d = {6'b0, state_q == IGNORE, wr_done_q};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
`ifdef SPI_RAM_TARGET_RDSR_EN
            rdsr_d    = 1'b0;
            wr_done_d = 1'b0;
`endif
          end
        end
        CMD: begin
          if (sck_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            case (rx_byte)
              8'h03: begin state_d = ADDR; is_wr_d = 1'b0; end
              8'h02: begin state_d = ADDR; is_wr_d = 1'b1; end
`ifdef SPI_RAM_TARGET_RDSR_EN
              8'h05: begin
                state_d = READ;
                rdsr_d  = 1'b1;
                tx_d    = status_q;
                pend_d  = 1'b0;
              end
`endif
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (sck_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            addr_d = rx_byte[AW-1:0];
            if (is_wr_q) begin
              state_d = WRITE;
            end else begin
              state_d = READ;
              tx_d    = mem_q[rx_byte[AW-1:0]];
              pend_d  = 1'b0;
            end
          end
        end
        READ: begin
          // Only falls that follow a data-phase rise shift; the fall right
          // after the address byte must leave the loaded MSB on miso.
          if (sck_rise) begin
            pend_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (sck_fall && pend_q) begin
            pend_d = 1'b0;
            if (bit_cnt_q == 3'd0) begin
              addr_d = addr_inc;
`ifdef SPI_RAM_TARGET_RDSR_EN
              tx_d   = rdsr_q ? status_q : mem_q[addr_inc];
`else
              tx_d   = mem_q[addr_inc];
`endif
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            spi_we = 1'b1;
            addr_d = addr_inc;
`ifdef SPI_RAM_TARGET_RDSR_EN
            wr_done_d = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'd0;
      tx_q       <= 8'd0;
      addr_q     <= '0;
      is_wr_q    <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      cs_prev_q  <= 1'b0;
      sck_prev_q <= 1'b0;
      bd_rdata_q <= 8'd0;
`ifdef SPI_RAM_TARGET_RDSR_EN
      status_q   <= 8'd0;
      rdsr_q     <= 1'b0;
      wr_done_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      is_wr_q    <= is_wr_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      cs_prev_q  <= cs_prev_d;
      sck_prev_q <= sck_sync_q;
      bd_rdata_q <= mem_q[bd_idx];
`ifdef SPI_RAM_TARGET_RDSR_EN
      status_q   <= status_d;
      rdsr_q     <= rdsr_d;
      wr_done_q  <= wr_done_d;
`endif
    end
  end

  // Storage is not reset; an SPI commit beats a backdoor write to the same byte.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (spi_we && addr_q == AW'(i))
        mem_q[i] <= rx_byte;
      else if (bd_we && bd_idx == AW'(i))
        mem_q[i] <= bd_wdata;
    end
  end

  assign miso     = (state_q == READ) & tx_q[7];
  assign miso_oe  = (state_q == READ);
  assign busy     = busy_q;
  assign bd_rdata = bd_rdata_q;

endmodule
